// File: rtl/mult_feeder.sv
// ============================================================================
//  Module      : mult_feeder
//  Description : Issue/collect stage around a fixed-latency signed multiplier.
//                Credit-guarded result FIFO so results are never dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_feeder #(
    parameter int DATA_LEN     = 32,
    parameter int TAG_LEN      = 4,
    parameter int MULT_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_a,
    input  logic [DATA_LEN-1:0] in_b,
    input  logic [TAG_LEN-1:0]  in_tag,
    output logic [DATA_LEN-1:0] mul_a,
    output logic [DATA_LEN-1:0] mul_b,
    input  logic [DATA_LEN-1:0] mul_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_result,
    output logic [TAG_LEN-1:0]  out_tag,
    output logic                busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FIFO_DEPTH);

    logic [c_CNT_W-1:0] r_credit;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    // One extra stage beyond MULT_LATENCY: the product is valid after edge
    // E+MULT_LATENCY and is captured into the FIFO on the following edge.
    logic               r_vld [0:MULT_LATENCY];
    logic [TAG_LEN-1:0] r_tag [0:MULT_LATENCY];

    logic [DATA_LEN-1:0] r_mem_data [0:FIFO_DEPTH-1];
    logic [TAG_LEN-1:0]  r_mem_tag  [0:FIFO_DEPTH-1];

    logic w_accept;
    logic w_pop;
    logic w_push;

    assign in_ready  = (r_credit < c_CNT_MAX);
    assign out_valid = (r_count != '0);
    assign busy      = (r_credit != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = r_vld[MULT_LATENCY];

    // Head is forced to zero while empty so stale entries are never visible.
    assign out_result = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_tag    = out_valid ? r_mem_tag[r_rd_ptr]  : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (w_accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MULT_LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_tag[0] <= in_tag;
            for (int i = 1; i <= MULT_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_credit <= r_credit + c_CNT_ONE;
                2'b01:   r_credit <= r_credit - c_CNT_ONE;
                default: r_credit <= r_credit;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= mul_result;
            r_mem_tag[r_wr_ptr]  <= r_tag[MULT_LATENCY];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_feeder.sv
// Testbench for mult_feeder: behavioural multiplier plus a result scoreboard
// filled on accepted handshakes and drained on output pops.
`default_nettype none

module tb_mult_feeder;

    localparam int DL = 32;
    localparam int TL = 4;
    localparam int LAT = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_a = '0;
    logic [DL-1:0] in_b = '0;
    logic [TL-1:0] in_tag = '0;
    logic [DL-1:0] mul_a;
    logic [DL-1:0] mul_b;
    logic [DL-1:0] mul_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DL-1:0] out_result;
    logic [TL-1:0] out_tag;
    logic          busy;

    mult_feeder #(
        .DATA_LEN(DL), .TAG_LEN(TL), .MULT_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Fixed-latency multiplier model: product valid LAT edges after operands
    logic [DL-1:0] mpipe [0:LAT-1];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= mul_a * mul_b;
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[LAT-1];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int pop_total = 0;
    int first_pop = -1;
    int last_pop = -1;
    bit mon_en = 1'b0;
    logic [DL-1:0] exp_res = '0;
    logic [DL+TL-1:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor; credit equals the number of outstanding entries.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            n_cmp++;
            if (in_ready !== (sb.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL in_ready_credit: got %b want %b (outstanding %0d)", in_ready, sb.size() < DEPTH, sb.size());
            end
            n_cmp++;
            if (busy !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL busy_credit: got %b want %b", busy, sb.size() != 0);
            end
            n_cmp++;
            if (sb.size() > DEPTH) begin
                n_fail++;
                $display("FAIL credit_bound: got %0d want <= %0d", sb.size(), DEPTH);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got %h/%h want none", out_result, out_tag);
                end else begin
                    logic [DL+TL-1:0] e;
                    e = sb.pop_front();
                    if ({out_result, out_tag} !== e) begin
                        n_fail++;
                        $display("FAIL result: got %h tag %h want %h tag %h", out_result, out_tag, e[DL+TL-1:TL], e[TL-1:0]);
                    end
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                    pop_total++;
                end
            end
            if (in_valid && in_ready) sb.push_back({exp_res, in_tag});
        end
    end

    task automatic send(input logic [DL-1:0] a, input logic [DL-1:0] b,
                        input logic [TL-1:0] t, input logic [DL-1:0] e);
        int w;
        w = 0;
        in_a = a; in_b = b; in_tag = t; exp_res = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid || busy) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding busy %b want 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== '0 || out_tag !== '0
            || mul_a !== '0 || mul_b !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy%b vld%b busy%b res %h tag %h ma %h mb %h want 1 0 0 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_tag, mul_a, mul_b);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send(32'd7, 32'hFFFF_FFFD, 4'd5, 32'hFFFF_FFEB);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== (k == 4)) begin
                n_fail++;
                $display("FAIL single_latency k=%0d: got out_valid %b want %b", k, out_valid, k == 4);
            end
            if (k == 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy: got %b want 1", busy);
                end
            end
        end
        n_cmp++;
        if (out_result !== 32'hFFFF_FFEB || out_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL single_value: got %h/%h want ffffffeb/5", out_result, out_tag);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        send(32'h7FFF_FFFF, 32'd2, 4'd1, 32'hFFFF_FFFE);
        send(32'h8000_0000, 32'hFFFF_FFFF, 4'd2, 32'h8000_0000);
        drain();
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            in_a = DL'(i + 3); in_b = DL'(i * 5 - 7); in_tag = TL'(i);
            exp_res = DL'(i + 3) * DL'(i * 5 - 7);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc != DEPTH) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DL-1:0] a, b;
        out_ready = 1'b1;
        stall_cnt = 0; pop_total = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom;
            send(a, b, TL'(i), a * b);
        end
        drain();
        n_cmp++;
        if (stall_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_stalls: got %0d want 0", stall_cnt);
        end
        n_cmp++;
        if (pop_total != 100 || last_pop - first_pop != 99) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got %0d pops over %0d cycles want 100 over 99", pop_total, last_pop - first_pop);
        end
    endtask

    task automatic test_random_ready();
        bit done;
        done = 1'b0;
        fork
            begin
                logic [DL-1:0] a, b;
                for (int i = 0; i < 80; i++) begin
                    a = $urandom; b = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
                    send(a, b, TL'($urandom), a * b);
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = $urandom_range(0, 1) == 1;
                    @(posedge clk); #1;
                end
            end
        join
        drain();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(DL'(i + 1), DL'(9), TL'(i), DL'((i + 1) * 9));
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_result !== '0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: got rdy%b vld%b busy%b res %h tag %h want 1 0 0 0 0",
                     in_ready, out_valid, busy, out_result, out_tag);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_result k=%0d: got out_valid %b res %h want 0", k, out_valid, out_result);
            end
        end
        @(posedge clk); #1;
        send(32'd6, 32'd7, 4'd9, 32'd42);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_random_ready();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
